// File: rtl/cp0_tlb_op_sequencer.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR from MEM: drives the TLB array ports, emits the
// CP0 update pulses, owns CP0 Random and requests a refetch after translation changes.
module cp0_tlb_op_sequencer #(
  parameter int TLB_NUM = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         MEM_tlbReq_i,
  input  logic [1:0]                   MEM_tlbOp_i,
  input  logic [31:0]                  MEM_tlbPC_i,
  input  logic                         CP0_excOccur_i,
  input  logic [31:0]                  CP0_EntryHi_i,
  input  logic [31:0]                  CP0_EntryLo0_i,
  input  logic [31:0]                  CP0_EntryLo1_i,
  input  logic [31:0]                  CP0_Index_i,
  input  logic                         TLB_hit_i,
  input  logic [$clog2(TLB_NUM)-1:0]   TLB_hitIndex_i,
  input  logic [95:0]                  TLB_rdData_i,
  output logic                         tlb_ready_o,
  output logic                         TLB_searchEn_o,
  output logic [26:0]                  TLB_searchKey_o,
  output logic                         TLB_rdEn_o,
  output logic                         TLB_wen_o,
  output logic [$clog2(TLB_NUM)-1:0]   TLB_index_o,
  output logic [95:0]                  TLB_wData_o,
  output logic                         DMMU_TLBPwrite_o,
  output logic                         DMMU_TLBRwrite_o,
  output logic [31:0]                  DMMU_Index_o,
  output logic [31:0]                  DMMU_EntryHi_o,
  output logic [31:0]                  DMMU_EntryLo0_o,
  output logic [31:0]                  DMMU_EntryLo1_o,
  output logic [31:0]                  CP0_Random_o,
  output logic                         tlb_flush_o,
  output logic [31:0]                  tlb_flushPC_o
);
  localparam int IDX_W = $clog2(TLB_NUM);
  localparam logic [IDX_W-1:0] RND_MAX = IDX_W'(TLB_NUM - 1);

  typedef enum logic [1:0] {OP_TLBP = 2'b00, OP_TLBR = 2'b01, OP_TLBWI = 2'b10, OP_TLBWR = 2'b11} op_e;
  typedef enum logic [2:0] {IDLE, SRCH, SRES, RD, RRES, WR, DONE} state_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [31:0]      pc_q, pc_d, ehi_q, ehi_d, lo0_q, lo0_d, lo1_q, lo1_d;
  logic [IDX_W-1:0] idx_q, idx_d, rnd_lat_q, rnd_lat_d, random_q, random_d;
  logic             ready_q, ready_d, srch_q, srch_d, rd_q, rd_d, wen_q, wen_d;
  logic             pw_q, pw_d, rw_q, rw_d, flush_q, flush_d;
  logic             accept;
  logic             unused_idx;

  assign unused_idx = ^CP0_Index_i[31:IDX_W];

  always_comb begin
    accept    = MEM_tlbReq_i & ready_q & ~CP0_excOccur_i;
    state_d   = state_q;
    op_d      = op_q;
    pc_d      = pc_q;
    ehi_d     = ehi_q;
    lo0_d     = lo0_q;
    lo1_d     = lo1_q;
    idx_d     = idx_q;
    rnd_lat_d = rnd_lat_q;
    random_d  = (random_q == '0) ? RND_MAX : random_q - 1'b1;
    if (accept) begin
      op_d      = op_e'(MEM_tlbOp_i);
      pc_d      = MEM_tlbPC_i;
      ehi_d     = CP0_EntryHi_i;
      lo0_d     = CP0_EntryLo0_i;
      lo1_d     = CP0_EntryLo1_i;
      idx_d     = CP0_Index_i[IDX_W-1:0];
      rnd_lat_d = random_q;
    end
    unique case (state_q)
      IDLE: if (accept) begin
        unique case (op_e'(MEM_tlbOp_i))
          OP_TLBP: state_d = SRCH;
          OP_TLBR: state_d = RD;
          default: state_d = WR;
        endcase
      end
      SRCH:    state_d = SRES;
      SRES:    state_d = DONE;
      RD:      state_d = RRES;
      RRES:    state_d = DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they come straight off flops.
    ready_d = (state_d == IDLE);
    srch_d  = (state_d == SRCH);
    pw_d    = (state_d == SRES);
    rd_d    = (state_d == RD);
    rw_d    = (state_d == RRES);
    wen_d   = (state_d == WR);
    flush_d = (state_d == DONE) && (state_q != DONE) && (op_q != OP_TLBP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= OP_TLBP;
      pc_q      <= '0;
      ehi_q     <= '0;
      lo0_q     <= '0;
      lo1_q     <= '0;
      idx_q     <= '0;
      rnd_lat_q <= '0;
      random_q  <= RND_MAX;
      ready_q   <= 1'b1;
      srch_q    <= 1'b0;
      pw_q      <= 1'b0;
      rd_q      <= 1'b0;
      rw_q      <= 1'b0;
      wen_q     <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pc_q      <= pc_d;
      ehi_q     <= ehi_d;
      lo0_q     <= lo0_d;
      lo1_q     <= lo1_d;
      idx_q     <= idx_d;
      rnd_lat_q <= rnd_lat_d;
      random_q  <= random_d;
      ready_q   <= ready_d;
      srch_q    <= srch_d;
      pw_q      <= pw_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      wen_q     <= wen_d;
      flush_q   <= flush_d;
    end
  end

  assign tlb_ready_o      = ready_q;
  assign TLB_searchEn_o   = srch_q;
  assign TLB_searchKey_o  = {ehi_q[31:13], ehi_q[7:0]};
  assign TLB_rdEn_o       = rd_q;
  assign TLB_wen_o        = wen_q;
  assign TLB_index_o      = (op_q == OP_TLBWR) ? rnd_lat_q : idx_q;
  assign TLB_wData_o      = {ehi_q, lo0_q, lo1_q};
  assign DMMU_TLBPwrite_o = pw_q;
  assign DMMU_TLBRwrite_o = rw_q;
  assign DMMU_Index_o     = {~TLB_hit_i, {(31-IDX_W){1'b0}}, TLB_hit_i ? TLB_hitIndex_i : {IDX_W{1'b0}}};
  assign DMMU_EntryHi_o   = TLB_rdData_i[95:64];
  assign DMMU_EntryLo0_o  = TLB_rdData_i[63:32];
  assign DMMU_EntryLo1_o  = TLB_rdData_i[31:0];
  assign CP0_Random_o     = {{(32-IDX_W){1'b0}}, random_q};
  assign tlb_flush_o      = flush_q;
  assign tlb_flushPC_o    = pc_q + 32'h4;

endmodule
